// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Parametrised VGA timing and test-pattern generator. A pixel-enable divider
//   steps the horizontal/vertical counters; every output is registered on the
//   pixel-enable edge from the pre-increment counter values. Two buttons step a
//   pending pattern mode that is committed only at the start of a frame.
//
//   Optional feature macro: VGA_DEBOUNCE_EN
//     defined   - each synchronised button level must be stable DEB_CYCLES clk
//                 before it is accepted; edges come from the accepted level.
//     undefined - edges are taken straight from the synchronised level.
//
// Ports
//   clk          in   system clock, rising edge
//   RST          in   asynchronous active-low reset (released through 2 flops)
//   btn_next     in   async button, advance pattern mode
//   btn_prev     in   async button, step pattern mode back
//   vga_r/g/b    out  COLOR_W-bit colour channels, 0 outside the visible area
//   vga_hsync    out  horizontal sync, active level HS_POL
//   vga_vsync    out  vertical sync, active level VS_POL
//   de           out  visible-area flag
//   x, y         out  position of the pixel currently on the pins
//   frame_start  out  1-clk pulse while the pins show pixel (0,0)
//   mode         out  active pattern (0 white, 1 bars, 2 checker, 3 grey ramp)

module vga_pattern_gen #(
  parameter int COLOR_W    = 4,
  parameter int PIX_DIV    = 2,
  parameter int H_VIS      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VIS      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int BAR_SHIFT  = 6,
  parameter int CHK_SHIFT  = 5,
  parameter int DEB_CYCLES = 500000,
  localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP,
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               btn_next,
  input  logic               btn_prev,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hsync,
  output logic               vga_vsync,
  output logic               de,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               frame_start,
  output logic [1:0]         mode
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  // ---------------------------------------------------------------------------
  // Reset: asserts asynchronously, releases on the second clk edge.
  // ---------------------------------------------------------------------------
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) r_rst_sync <= 2'b00;
    else      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // ---------------------------------------------------------------------------
  // Pixel-enable divider: down-counter, pix_en on terminal count 0. Reset
  // leaves it at 0 so the first clk after release is already a pixel edge.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] r_div;
  logic             w_pix_en;

  assign w_pix_en = (r_div == '0);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)      r_div <= '0;
    else if (w_pix_en) r_div <= DIV_W'(PIX_DIV - 1);
    else               r_div <= r_div - DIV_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [XW-1:0] r_h_cnt;
  logic [YW-1:0] r_v_cnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last = (r_h_cnt == XW'(H_TOTAL - 1));
  assign w_v_last = (r_v_cnt == YW'(V_TOTAL - 1));

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_pix_en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + YW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + XW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Buttons: 2-flop synchroniser, optional debounce, rising-edge detect.
  // Bit 0 = next, bit 1 = prev.
  // ---------------------------------------------------------------------------
  logic [1:0] w_btn_raw;
  logic [1:0] r_btn_s0;
  logic [1:0] r_btn_s1;
  logic [1:0] w_btn_lvl;
  logic [1:0] r_btn_lvl_d;
  logic [1:0] w_btn_rise;

  assign w_btn_raw = {btn_prev, btn_next};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_btn_s0 <= '0;
      r_btn_s1 <= '0;
    end else begin
      r_btn_s0 <= w_btn_raw;
      r_btn_s1 <= r_btn_s0;
    end
  end

`ifdef VGA_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [DEB_W-1:0] r_deb_cnt [2];
  logic [1:0]       r_deb_cand;
  logic [1:0]       r_deb_acc;

  // r_deb_cand follows the synchronised level; any change reloads the timer.
  // The candidate is accepted once the timer has run down while it held.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_deb_cnt[0] <= '0;
      r_deb_cnt[1] <= '0;
      r_deb_cand   <= '0;
      r_deb_acc    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_btn_s1[i] != r_deb_cand[i]) begin
          r_deb_cand[i] <= r_btn_s1[i];
          r_deb_cnt[i]  <= DEB_W'(DEB_CYCLES - 1);
        end else if (r_deb_cand[i] != r_deb_acc[i]) begin
          if (r_deb_cnt[i] == '0) r_deb_acc[i] <= r_deb_cand[i];
          else                    r_deb_cnt[i] <= r_deb_cnt[i] - DEB_W'(1);
        end
      end
    end
  end

  assign w_btn_lvl = r_deb_acc;
`else
  assign w_btn_lvl = r_btn_s1;

  // DEB_CYCLES only matters when the debouncer is compiled in.
  if (DEB_CYCLES < 1) begin : g_deb_cycles_unused
  end
`endif

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_btn_lvl_d <= '0;
    else          r_btn_lvl_d <= w_btn_lvl;
  end

  assign w_btn_rise = w_btn_lvl & ~r_btn_lvl_d;

  // ---------------------------------------------------------------------------
  // Pending / active mode. Simultaneous next+prev edges cancel out.
  // ---------------------------------------------------------------------------
  logic [1:0] r_pending;
  logic [1:0] r_mode;
  logic [1:0] w_mode_cur;
  logic       w_frame;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pending <= '0;
    end else begin
      case (w_btn_rise)
        2'b01:   r_pending <= r_pending + 2'd1;
        2'b10:   r_pending <= r_pending - 2'd1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign w_frame = w_pix_en && (r_h_cnt == '0) && (r_v_cnt == '0);

  // The pixel (0,0) is already drawn with the newly committed mode so the
  // whole frame uses one pattern.
  assign w_mode_cur = w_frame ? r_pending : r_mode;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n)     r_mode <= '0;
    else if (w_frame) r_mode <= r_pending;
  end

  // ---------------------------------------------------------------------------
  // Timing decode and pattern generation from the pre-increment counters
  // ---------------------------------------------------------------------------
  logic [31:0]        w_hx;
  logic [31:0]        w_vy;
  logic               w_hs_act;
  logic               w_vs_act;
  logic               w_de;
  logic [2:0]         w_bar_idx;
  logic               w_chk_bit;
  logic [COLOR_W-1:0] w_grey;
  logic [COLOR_W-1:0] w_r;
  logic [COLOR_W-1:0] w_g;
  logic [COLOR_W-1:0] w_b;

  assign w_hx = 32'(r_h_cnt);
  assign w_vy = 32'(r_v_cnt);

  assign w_hs_act = (w_hx >= 32'(H_VIS + H_FP)) && (w_hx < 32'(H_VIS + H_FP + H_SYNC));
  assign w_vs_act = (w_vy >= 32'(V_VIS + V_FP)) && (w_vy < 32'(V_VIS + V_FP + V_SYNC));
  assign w_de     = (w_hx < 32'(H_VIS)) && (w_vy < 32'(V_VIS));

  assign w_bar_idx = 3'(w_hx >> BAR_SHIFT);
  assign w_chk_bit = 1'((w_hx >> CHK_SHIFT) ^ (w_vy >> CHK_SHIFT));
  // x[COLOR_W+2:3]; the 32-bit extension keeps this valid for narrow x.
  assign w_grey    = COLOR_W'(w_hx >> 3);

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_de) begin
      case (w_mode_cur)
        2'd0: begin
          w_r = '1;
          w_g = '1;
          w_b = '1;
        end
        2'd1: begin
          w_r = {COLOR_W{w_bar_idx[2]}};
          w_g = {COLOR_W{w_bar_idx[1]}};
          w_b = {COLOR_W{w_bar_idx[0]}};
        end
        2'd2: begin
          w_r = {COLOR_W{w_chk_bit}};
          w_g = {COLOR_W{w_chk_bit}};
          w_b = {COLOR_W{w_chk_bit}};
        end
        default: begin
          w_r = w_grey;
          w_g = w_grey;
          w_b = w_grey;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers: update on pix_en, hold in between.
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0] r_r;
  logic [COLOR_W-1:0] r_g;
  logic [COLOR_W-1:0] r_b;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_de;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic               r_frame_start;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (w_pix_en) begin
      r_r     <= w_r;
      r_g     <= w_g;
      r_b     <= w_b;
      r_hsync <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync <= w_vs_act ? VS_POL : ~VS_POL;
      r_de    <= w_de;
      r_x     <= r_h_cnt;
      r_y     <= r_v_cnt;
    end
  end

  // Single-clk pulse, even when PIX_DIV holds the pixel for several clk.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_frame_start <= 1'b0;
    else          r_frame_start <= w_frame;
  end

  assign vga_r       = r_r;
  assign vga_g       = r_g;
  assign vga_b       = r_b;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign de          = r_de;
  assign x           = r_x;
  assign y           = r_y;
  assign frame_start = r_frame_start;
  assign mode        = r_mode;

endmodule
